// File: rtl/pic_pkg.sv
// Shared types and helpers for the 8259A interrupt-acknowledge path.
package pic_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACK1  = 2'd1,
        WAIT2 = 2'd2,
        ACK2  = 2'd3
    } state_t;

    // Vector low bits returned when no request survives to the first INTA.
    localparam logic [2:0] SPURIOUS_ID = 3'd7;

    function automatic logic [7:0] onehot8(input logic [2:0] id);
        return 8'd1 << id;
    endfunction

    function automatic logic [7:0] vector(input logic [4:0] icw2, input logic [2:0] id);
        return {icw2, id};
    endfunction

endpackage

// File: rtl/inta_sequencer_if.sv
// INTA / cascade / data-bus signals between the CPU-side bus and the sequencer.
interface inta_sequencer_if;
    logic       inta_n;
    logic       slave_match;
    logic       int_out;
    logic [2:0] cas_out;
    logic       cas_oe;
    logic [7:0] data_out;
    logic       data_oe;
    logic       slave_match_ack;

    modport master (
        output inta_n, slave_match,
        input  int_out, cas_out, cas_oe, data_out, data_oe, slave_match_ack
    );

    modport slave (
        input  inta_n, slave_match,
        output int_out, cas_out, cas_oe, data_out, data_oe, slave_match_ack
    );
endinterface

// File: rtl/priority_resolver.sv
// Combinational 8-input priority encoder: lowest set index wins.
module priority_resolver (
    input  logic [7:0] i_vec,
    output logic       o_valid,
    output logic [2:0] o_id
);
    always_comb begin
        o_valid = |i_vec;
        o_id    = 3'd0;
        // Scan downwards so the lowest set bit is the last one written.
        for (int i = 7; i >= 0; i--) begin
            if (i_vec[i]) o_id = 3'(i);
        end
    end
endmodule

// File: rtl/inta_sequencer.sv
// Interrupt-acknowledge sequencer: picks the winning IR and runs the two-pulse INTA cycle.
module inta_sequencer
    import pic_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    inta_sequencer_if.slave   bus,
    input  logic              sp,
    input  logic              sngl,
    input  logic              aeoi,
    input  logic [4:0]        icw2,
    input  logic [7:0]        icw3,
    input  logic [7:0]        irr,
    input  logic [7:0]        imr,
    input  logic [7:0]        isr,
    output logic [7:0]        irr_clr,
    output logic [7:0]        isr_set,
    output logic [7:0]        isr_clr
);
    logic       w_req_valid, w_isr_valid;
    logic [2:0] w_win_id, w_isr_id, w_id;
    logic [3:0] w_level;
    logic       w_int_req, w_fall, w_rise, w_cas, w_local;

    state_t     r_state;
    logic       r_inta_q;
    logic       r_int_out;
    logic [2:0] r_id;
    logic       r_local, r_slave, r_aeoi;
    logic [7:0] r_vec;
    logic [2:0] r_cas_out;
    logic       r_cas_oe;
    logic [7:0] r_data_out;
    logic       r_data_oe;
    logic       r_smack;
    logic [7:0] r_irr_clr, r_isr_set, r_isr_clr;

    priority_resolver u_req_pr (
        .i_vec   (irr & ~imr),
        .o_valid (w_req_valid),
        .o_id    (w_win_id)
    );

    priority_resolver u_isr_pr (
        .i_vec   (isr),
        .o_valid (w_isr_valid),
        .o_id    (w_isr_id)
    );

    assign w_level   = w_isr_valid ? {1'b0, w_isr_id} : 4'd8;
    assign w_int_req = w_req_valid && ({1'b0, w_win_id} < w_level);

    assign w_fall = r_inta_q & ~bus.inta_n;
    assign w_rise = ~r_inta_q & bus.inta_n;

    // Everything the second INTA needs is decided from the id latched at the first fall.
    assign w_id    = w_req_valid ? w_win_id : SPURIOUS_ID;
    assign w_cas   = sp & ~sngl & icw3[w_id];
    assign w_local = sngl | (sp & ~icw3[w_id]);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_inta_q   <= 1'b1;
            r_int_out  <= 1'b0;
            r_id       <= 3'd0;
            r_local    <= 1'b0;
            r_slave    <= 1'b0;
            r_aeoi     <= 1'b0;
            r_vec      <= 8'd0;
            r_cas_out  <= 3'd0;
            r_cas_oe   <= 1'b0;
            r_data_out <= 8'd0;
            r_data_oe  <= 1'b0;
            r_smack    <= 1'b0;
            r_irr_clr  <= 8'd0;
            r_isr_set  <= 8'd0;
            r_isr_clr  <= 8'd0;
        end else begin
            r_inta_q  <= bus.inta_n;
            r_int_out <= 1'b0;
            r_irr_clr <= 8'd0;
            r_isr_set <= 8'd0;
            r_isr_clr <= 8'd0;
            case (r_state)
                IDLE: begin
                    if (w_fall) begin
                        r_id    <= w_id;
                        r_local <= w_local;
                        r_slave <= ~sp;
                        r_aeoi  <= aeoi & w_req_valid;
                        r_vec   <= vector(icw2, w_id);
                        if (w_req_valid) begin
                            r_isr_set <= onehot8(w_id);
                            r_irr_clr <= onehot8(w_id);
                        end
                        if (w_cas) begin
                            r_cas_out <= w_id;
                            r_cas_oe  <= 1'b1;
                        end
                        r_state <= ACK1;
                    end else begin
                        r_int_out <= w_int_req;
                    end
                end
                ACK1: begin
                    if (w_rise) r_state <= WAIT2;
                end
                WAIT2: begin
                    if (w_fall) begin
                        if (r_local | (r_slave & bus.slave_match)) begin
                            r_data_out <= r_vec;
                            r_data_oe  <= 1'b1;
                        end
                        r_state <= ACK2;
                    end
                end
                ACK2: begin
                    if (w_rise) begin
                        r_data_oe <= 1'b0;
                        r_cas_oe  <= 1'b0;
                        if (r_aeoi) r_isr_clr <= onehot8(r_id);
                        if (r_slave) r_smack <= ~r_smack;
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.int_out         = r_int_out;
    assign bus.cas_out         = r_cas_out;
    assign bus.cas_oe          = r_cas_oe;
    assign bus.data_out        = r_data_out;
    assign bus.data_oe         = r_data_oe;
    assign bus.slave_match_ack = r_smack;
    assign irr_clr             = r_irr_clr;
    assign isr_set             = r_isr_set;
    assign isr_clr             = r_isr_clr;

endmodule

// File: tb/tb_inta_sequencer.sv
// Directed bench for inta_sequencer with a queue of expected results.
module tb_inta_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       sp, sngl, aeoi;
    logic [4:0] icw2;
    logic [7:0] icw3, irr, imr, isr;
    logic [7:0] irr_clr, isr_set, isr_clr;

    inta_sequencer_if bus ();

    inta_sequencer dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus),
        .sp      (sp),
        .sngl    (sngl),
        .aeoi    (aeoi),
        .icw2    (icw2),
        .icw3    (icw3),
        .irr     (irr),
        .imr     (imr),
        .isr     (isr),
        .irr_clr (irr_clr),
        .isr_set (isr_set),
        .isr_clr (isr_clr)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [31:0] exp;
    } sb_t;

    sb_t sb[$];
    int  n_cmp  = 0;
    int  n_fail = 0;

    // Free-running monitor: totals and last non-zero values, sampled on the falling edge.
    int         m_isr_set_n = 0, m_irr_clr_n = 0, m_isr_clr_n = 0;
    int         m_doe_n = 0, m_coe_n = 0, m_smack_tog = 0;
    logic [7:0] m_isr_set = 8'd0, m_irr_clr = 8'd0, m_isr_clr = 8'd0, m_data = 8'd0;
    logic [2:0] m_cas = 3'd0;
    logic       m_smack_prev = 1'b0, m_doe_prev = 1'b0, m_clr_prev_doe = 1'b0;

    always @(negedge clk) begin
        if (isr_set != 8'd0) begin m_isr_set = isr_set; m_isr_set_n++; end
        if (irr_clr != 8'd0) begin m_irr_clr = irr_clr; m_irr_clr_n++; end
        if (isr_clr != 8'd0) begin m_isr_clr = isr_clr; m_isr_clr_n++; m_clr_prev_doe = m_doe_prev; end
        if (bus.data_oe === 1'b1) begin m_data = bus.data_out; m_doe_n++; end
        if (bus.cas_oe === 1'b1) begin m_cas = bus.cas_out; m_coe_n++; end
        if (bus.slave_match_ack !== m_smack_prev) m_smack_tog++;
        m_smack_prev = bus.slave_match_ack;
        m_doe_prev   = bus.data_oe;
    end

    int s_isr_set_n, s_irr_clr_n, s_isr_clr_n, s_doe_n, s_coe_n, s_smack_tog;

    task automatic snap();
        s_isr_set_n = m_isr_set_n;
        s_irr_clr_n = m_irr_clr_n;
        s_isr_clr_n = m_isr_clr_n;
        s_doe_n     = m_doe_n;
        s_coe_n     = m_coe_n;
        s_smack_tog = m_smack_tog;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_push(input string tag, input logic [31:0] exp);
        sb_t e;
        e.tag = tag;
        e.exp = exp;
        sb.push_back(e);
    endtask

    task automatic chk(input logic [31:0] obs);
        sb_t e;
        n_cmp++;
        if (sb.size() == 0) begin
            n_fail++;
            $error("FAIL sb_underflow: observed %0h required nothing queued", obs);
        end else begin
            e = sb.pop_front();
            assert (obs === e.exp) else begin
                n_fail++;
                $error("FAIL %s: observed %0h required %0h", e.tag, obs, e.exp);
            end
        end
    endtask

    // Two INTA pulses: w1 low, g high, w2 low; irr is rewritten during the gap.
    task automatic run_inta(input int w1, input int g, input int w2, input logic [7:0] irr_gap);
        bus.inta_n = 1'b0;
        repeat (w1) tick();
        bus.inta_n = 1'b1;
        irr = irr_gap;
        repeat (g) tick();
        bus.inta_n = 1'b0;
        repeat (w2) tick();
        bus.inta_n = 1'b1;
        repeat (3) tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1;
        bus.inta_n = 1'b1;
        bus.slave_match = 1'b0;
        sp = 1'b1; sngl = 1'b1; aeoi = 1'b0;
        icw2 = 5'h08; icw3 = 8'h00;
        irr = 8'h00; imr = 8'h00; isr = 8'h00;
        repeat (3) tick();

        expect_push("reset_bus", 32'd0);
        expect_push("reset_pulses", 32'd0);
        chk({bus.int_out, bus.cas_oe, bus.data_oe, bus.cas_out, bus.data_out, bus.slave_match_ack});
        chk({irr_clr, isr_set, isr_clr});
        rst = 1'b0;

        // Single PIC, IR2 and IR5 pending: IR2 wins, vector 0x42.
        irr = 8'h24;
        expect_push("single_int_out", 32'd1);
        repeat (2) tick();
        chk(bus.int_out);
        snap();
        expect_push("single_isr_set", 32'h04);
        expect_push("single_isr_set_n", 32'd1);
        expect_push("single_irr_clr", 32'h04);
        expect_push("single_irr_clr_n", 32'd1);
        expect_push("single_vector", 32'h42);
        expect_push("single_doe_cycles", 32'd3);
        expect_push("single_cas_oe_cycles", 32'd0);
        expect_push("single_isr_clr_n", 32'd0);
        run_inta(2, 1, 3, 8'h24);
        chk(m_isr_set); chk(m_isr_set_n - s_isr_set_n);
        chk(m_irr_clr); chk(m_irr_clr_n - s_irr_clr_n);
        chk(m_data);    chk(m_doe_n - s_doe_n);
        chk(m_coe_n - s_coe_n); chk(m_isr_clr_n - s_isr_clr_n);

        // Master, slave on IR3: cascade drives the vector, master keeps the data bus off.
        sngl = 1'b0; icw3 = 8'h08; irr = 8'h08;
        repeat (2) tick();
        snap();
        expect_push("master_cas_out", 32'd3);
        expect_push("master_cas_oe_cycles", 32'd5);
        expect_push("master_doe_cycles", 32'd0);
        expect_push("master_isr_set", 32'h08);
        run_inta(1, 2, 2, 8'h08);
        chk(m_cas); chk(m_coe_n - s_coe_n); chk(m_doe_n - s_doe_n); chk(m_isr_set);

        // Master, IR1 has no slave: vector comes from the master itself.
        irr = 8'h02;
        repeat (2) tick();
        snap();
        expect_push("master_local_vector", 32'h41);
        expect_push("master_local_doe_cycles", 32'd2);
        expect_push("master_local_cas_oe_cycles", 32'd0);
        run_inta(1, 1, 2, 8'h02);
        chk(m_data); chk(m_doe_n - s_doe_n); chk(m_coe_n - s_coe_n);

        // Slave addressed at the second fall.
        sp = 1'b0; icw3 = 8'h03; icw2 = 5'h0C; irr = 8'h10; bus.slave_match = 1'b1;
        repeat (2) tick();
        snap();
        expect_push("slave_vector", 32'h64);
        expect_push("slave_doe_cycles", 32'd2);
        expect_push("slave_cas_oe_cycles", 32'd0);
        expect_push("slave_ack_toggles", 32'd1);
        expect_push("slave_isr_set", 32'h10);
        run_inta(2, 1, 2, 8'h10);
        chk(m_data); chk(m_doe_n - s_doe_n); chk(m_coe_n - s_coe_n);
        chk(m_smack_tog - s_smack_tog); chk(m_isr_set);

        // Slave not addressed: still sets ISR, but stays off the data bus.
        bus.slave_match = 1'b0;
        repeat (2) tick();
        snap();
        expect_push("slave_nomatch_doe_cycles", 32'd0);
        expect_push("slave_nomatch_isr_set_n", 32'd1);
        expect_push("slave_nomatch_ack_toggles", 32'd1);
        run_inta(2, 1, 2, 8'h10);
        chk(m_doe_n - s_doe_n); chk(m_isr_set_n - s_isr_set_n); chk(m_smack_tog - s_smack_tog);

        // Spurious: request gone before the first INTA.
        sp = 1'b1; sngl = 1'b1; aeoi = 1'b1; icw2 = 5'h10; irr = 8'h00;
        expect_push("spurious_int_out", 32'd0);
        repeat (2) tick();
        chk(bus.int_out);
        snap();
        expect_push("spurious_isr_set_n", 32'd0);
        expect_push("spurious_irr_clr_n", 32'd0);
        expect_push("spurious_vector", 32'h87);
        expect_push("spurious_isr_clr_n", 32'd0);
        run_inta(1, 1, 1, 8'h00);
        chk(m_isr_set_n - s_isr_set_n); chk(m_irr_clr_n - s_irr_clr_n);
        chk(m_data); chk(m_isr_clr_n - s_isr_clr_n);

        // AEOI on IR5; a new IR0 request mid-sequence must not change the vector.
        icw2 = 5'h08; irr = 8'h20;
        repeat (2) tick();
        snap();
        expect_push("aeoi_isr_set", 32'h20);
        expect_push("aeoi_isr_clr", 32'h20);
        expect_push("aeoi_isr_clr_n", 32'd1);
        expect_push("aeoi_clr_after_rise", 32'd1);
        expect_push("aeoi_frozen_vector", 32'h45);
        run_inta(2, 2, 2, 8'h01);
        chk(m_isr_set); chk(m_isr_clr); chk(m_isr_clr_n - s_isr_clr_n);
        chk(m_clr_prev_doe); chk(m_data);

        // Nesting and masking against the in-service level.
        isr = 8'h04; irr = 8'h08;
        expect_push("nest_lower_prio", 32'd0);
        repeat (2) tick();
        chk(bus.int_out);
        isr = 8'h10;
        expect_push("nest_higher_prio", 32'd1);
        repeat (2) tick();
        chk(bus.int_out);
        isr = 8'h00; irr = 8'h24; imr = 8'h24;
        expect_push("all_masked", 32'd0);
        repeat (2) tick();
        chk(bus.int_out);
        imr = 8'h00;

        // Reset while waiting for the second INTA.
        sp = 1'b1; sngl = 1'b0; aeoi = 1'b1; icw3 = 8'h08; irr = 8'h08;
        repeat (2) tick();
        snap();
        bus.inta_n = 1'b0;
        repeat (2) tick();
        bus.inta_n = 1'b1;
        repeat (2) tick();
        expect_push("wait2_cas_oe", 32'd1);
        chk(bus.cas_oe);
        rst = 1'b1;
        tick();
        expect_push("rst_mid_bus", 32'd0);
        expect_push("rst_mid_pulses", 32'd0);
        chk({bus.int_out, bus.cas_oe, bus.data_oe, bus.cas_out, bus.data_out, bus.slave_match_ack});
        chk({irr_clr, isr_set, isr_clr});
        rst = 1'b0;
        expect_push("rst_mid_no_aeoi", 32'd0);
        expect_push("rst_mid_int_out", 32'd1);
        repeat (3) tick();
        chk(m_isr_clr_n - s_isr_clr_n);
        chk(bus.int_out);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
